preview_fifo_packer: RTL and testbench

- Downstream consumer of preview_fifo.
- Pulls 0, 1 or 2 words per cycle from the FIFO preview port (od0/od1, rdreq one-hot) and packs them little-endian into WORDS-wide output words.
- Output side is a valid/ready stream with one holding register.
- A flush request emits a partial word with its valid-word count, so packet tails are not stranded.

---
 rtl/preview_fifo_packer.sv | 113 +++++++++++
 tb/tb_preview_fifo_packer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/preview_fifo_packer.sv
// Packs 0..2 preview-FIFO words per cycle, little-endian, into WORDS-wide output words.
// The output side is a valid/ready stream with one holding slot. A flush emits a partial word and its lane count.

module preview_fifo_packer_lane #(
   parameter int WIDTH = 8,
   parameter int CW    = 3,
   parameter int LANE  = 0
) (
   input  logic [CW-1:0]    cnt,
   input  logic [1:0]       n,
   input  logic [WIDTH-1:0] od0,
   input  logic [WIDTH-1:0] od1,
   input  logic [WIDTH-1:0] cur,
   output logic [WIDTH-1:0] nxt
);
   localparam logic [CW-1:0] L0 = CW'(LANE);
   localparam logic [CW-1:0] L1 = CW'((LANE > 0) ? LANE - 1 : 0);

   // od0 lands at lane cnt. On a double pop, od1 lands at lane cnt+1.
   always_comb begin
      nxt = cur;
      if (n != 2'd0 && cnt == L0) nxt = od0;
      if (LANE > 0 && n == 2'd2 && cnt == L1) nxt = od1;
   end
endmodule

module preview_fifo_packer #(
   parameter int WIDTH = 8,
   parameter int WORDS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                empty,
   input  logic [WIDTH-1:0]          od0,
   input  logic [WIDTH-1:0]          od1,
   output logic [2:0]                rdreq,
   input  logic                      flush,
   output logic [WIDTH*WORDS-1:0]    out_data,
   output logic [$clog2(WORDS+1)-1:0] out_cnt,
   output logic                      out_valid,
   input  logic                      out_ready
);
   localparam int CW = $clog2(WORDS+1);
   localparam logic [CW-1:0] FULL = CW'(WORDS);

   logic [WORDS-1:0][WIDTH-1:0] acc, acc_nxt, slot;
   logic [CW-1:0] cnt, nc, space;
   logic [1:0]    n;
   logic          flush_pend, slot_free;

   assign slot_free = !out_valid || out_ready;
   assign space     = FULL - cnt;
   assign nc        = cnt + CW'(n);
   assign out_data  = slot;

   always_comb begin
      rdreq = 3'b001;
      n     = 2'd0;
      if (!rst && !flush_pend && cnt != FULL) begin
         if (!empty[1] && space >= CW'(2)) begin
            rdreq = 3'b100;
            n     = 2'd2;
         end else if (!empty[0] && space >= CW'(1)) begin
            rdreq = 3'b010;
            n     = 2'd1;
         end
      end
   end

   for (genvar k = 0; k < WORDS; k++) begin : g_lane
      preview_fifo_packer_lane #(.WIDTH(WIDTH), .CW(CW), .LANE(k)) u_lane (
         .cnt (cnt),
         .n   (n),
         .od0 (od0),
         .od1 (od1),
         .cur (acc[k]),
         .nxt (acc_nxt[k])
      );
   end

   // acc lanes at or above cnt are always zero, so a flushed word has zero upper lanes.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         cnt        <= '0;
         flush_pend <= 1'b0;
         slot       <= '0;
         out_cnt    <= '0;
         out_valid  <= 1'b0;
      end else begin
         if (nc == FULL && slot_free) begin
            slot      <= acc_nxt;
            out_cnt   <= FULL;
            out_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
         end else if (flush_pend && slot_free && cnt != '0) begin
            slot      <= acc;
            out_cnt   <= cnt;
            out_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
         end else begin
            acc <= acc_nxt;
            cnt <= nc;
            if (out_ready) out_valid <= 1'b0;
         end
         // A pending flush blocks reads, so it resolves as soon as the slot is free or nothing is buffered.
         if (flush_pend) flush_pend <= !(slot_free || cnt == '0);
         else            flush_pend <= flush;
      end
   end
endmodule

// File: tb/tb_preview_fifo_packer.sv
// Directed bench for preview_fifo_packer (WIDTH=8, WORDS=4), with a queue standing in for the preview FIFO.

module tb_preview_fifo_packer;
   logic        clk, rst, flush, out_ready;
   logic [1:0]  empty;
   logic [7:0]  od0, od1;
   logic [2:0]  rdreq;
   logic [31:0] out_data;
   logic [2:0]  out_cnt;
   logic        out_valid;

   logic [7:0] q[$];
   logic       one_max;
   int         vec, err;

   preview_fifo_packer #(.WIDTH(8), .WORDS(4)) dut (
      .clk(clk), .rst(rst), .empty(empty), .od0(od0), .od1(od1), .rdreq(rdreq),
      .flush(flush), .out_data(out_data), .out_cnt(out_cnt), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_fifo();
      empty[0] = (q.size() == 0);
      empty[1] = (q.size() < 2) || one_max;
      od0 = (q.size() > 0) ? q[0] : 8'h00;
      od1 = (q.size() > 1) ? q[1] : 8'h00;
   endtask

   task automatic settle();
      drive_fifo();
      #1;
   endtask

   // The FIFO model pops whatever rdreq requested at the edge.
   task automatic tick();
      logic [2:0] r;
      logic [7:0] tmp;
      r = rdreq;
      @(posedge clk);
      if (r == 3'b010) tmp = q.pop_front();
      else if (r == 3'b100) begin tmp = q.pop_front(); tmp = q.pop_front(); end
      #1;
      settle();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 8; i++) q.push_back(8'h11 + 8'(i));
      settle();
      tick();
      tick();
      vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      vec++; if (out_cnt !== 3'd0) begin err++; $display("FAIL reset_cnt: got %0d want 0", out_cnt); end
      vec++; if (out_data !== 32'h0) begin err++; $display("FAIL reset_data: got %h want 0", out_data); end
      vec++; if (rdreq !== 3'b001) begin err++; $display("FAIL reset_rdreq: got %b want 001", rdreq); end
      vec++; if (q.size() != 8) begin err++; $display("FAIL reset_nopop: got %0d words want 8", q.size()); end
      rst = 1'b0;
      settle();
   endtask

   task automatic test_stream();
      for (int i = 0; i < 4; i++) begin
         vec++; if (rdreq !== 3'b100) begin err++; $display("FAIL stream_rdreq%0d: got %b want 100", i, rdreq); end
         tick();
         if (i == 1) begin
            vec++; if (out_valid !== 1'b1 || out_data !== 32'h14131211 || out_cnt !== 3'd4) begin
               err++; $display("FAIL stream_word0: got v=%b %h cnt=%0d want v=1 14131211 cnt=4", out_valid, out_data, out_cnt); end
         end else if (i == 3) begin
            vec++; if (out_valid !== 1'b1 || out_data !== 32'h18171615 || out_cnt !== 3'd4) begin
               err++; $display("FAIL stream_word1: got v=%b %h cnt=%0d want v=1 18171615 cnt=4", out_valid, out_data, out_cnt); end
         end else begin
            vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL stream_idle%0d: got %b want 0", i, out_valid); end
         end
      end
      vec++; if (rdreq !== 3'b001) begin err++; $display("FAIL stream_empty_rdreq: got %b want 001", rdreq); end
      tick();
      vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL stream_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_single();
      one_max = 1'b1;
      for (int i = 0; i < 4; i++) q.push_back(8'h5A);
      settle();
      for (int i = 0; i < 4; i++) begin
         vec++; if (rdreq !== 3'b010) begin err++; $display("FAIL single_rdreq%0d: got %b want 010", i, rdreq); end
         tick();
         if (i < 3) begin
            vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL single_idle%0d: got %b want 0", i, out_valid); end
         end
      end
      vec++; if (out_valid !== 1'b1 || out_data !== 32'h5A5A5A5A || out_cnt !== 3'd4) begin
         err++; $display("FAIL single_word: got v=%b %h cnt=%0d want v=1 5a5a5a5a cnt=4", out_valid, out_data, out_cnt); end
      one_max = 1'b0;
      tick();
   endtask

   task automatic test_odd();
      q.push_back(8'h21);
      settle();
      vec++; if (rdreq !== 3'b010) begin err++; $display("FAIL odd_first: got %b want 010", rdreq); end
      tick();
      q.push_back(8'h22); q.push_back(8'h23);
      settle();
      vec++; if (rdreq !== 3'b100) begin err++; $display("FAIL odd_pair: got %b want 100", rdreq); end
      tick();
      q.push_back(8'h24); q.push_back(8'h31); q.push_back(8'h32);
      settle();
      vec++; if (rdreq !== 3'b010) begin err++; $display("FAIL odd_space1: got %b want 010", rdreq); end
      tick();
      vec++; if (out_valid !== 1'b1 || out_data !== 32'h24232221) begin
         err++; $display("FAIL odd_word: got v=%b %h want v=1 24232221", out_valid, out_data); end
      vec++; if (rdreq !== 3'b100) begin err++; $display("FAIL odd_fresh: got %b want 100", rdreq); end
      tick();
      q.push_back(8'h33); q.push_back(8'h34);
      settle();
      tick();
      vec++; if (out_valid !== 1'b1 || out_data !== 32'h34333231) begin
         err++; $display("FAIL odd_word2: got v=%b %h want v=1 34333231", out_valid, out_data); end
      tick();
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 10; i++) q.push_back(8'h41 + 8'(i));
      settle();
      tick();
      tick();
      out_ready = 1'b0;
      settle();
      vec++; if (out_valid !== 1'b1 || out_data !== 32'h44434241) begin
         err++; $display("FAIL bp_first: got v=%b %h want v=1 44434241", out_valid, out_data); end
      tick();
      tick();
      vec++; if (rdreq !== 3'b001) begin err++; $display("FAIL bp_stall: got %b want 001", rdreq); end
      tick();
      vec++; if (out_valid !== 1'b1 || out_data !== 32'h44434241 || rdreq !== 3'b001) begin
         err++; $display("FAIL bp_hold: got v=%b %h rdreq=%b want v=1 44434241 001", out_valid, out_data, rdreq); end
      out_ready = 1'b1;
      settle();
      tick();
      vec++; if (out_valid !== 1'b1 || out_data !== 32'h48474645 || out_cnt !== 3'd4) begin
         err++; $display("FAIL bp_b2b: got v=%b %h cnt=%0d want v=1 48474645 cnt=4", out_valid, out_data, out_cnt); end
      vec++; if (rdreq !== 3'b100) begin err++; $display("FAIL bp_resume: got %b want 100", rdreq); end
      tick();
      vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL bp_accept: got %b want 0", out_valid); end
      flush = 1'b1;
      settle();
      tick();
      flush = 1'b0;
      settle();
      tick();
      vec++; if (out_valid !== 1'b1 || out_data !== 32'h00004A49 || out_cnt !== 3'd2) begin
         err++; $display("FAIL bp_flush: got v=%b %h cnt=%0d want v=1 00004a49 cnt=2", out_valid, out_data, out_cnt); end
      tick();
   endtask

   task automatic test_flush();
      q.push_back(8'hA1); q.push_back(8'hA2); q.push_back(8'hA3);
      settle();
      tick();
      vec++; if (rdreq !== 3'b010) begin err++; $display("FAIL flush_tail: got %b want 010", rdreq); end
      tick();
      flush = 1'b1;
      settle();
      tick();
      flush = 1'b0;
      q.push_back(8'hA4); q.push_back(8'hA5);
      settle();
      vec++; if (rdreq !== 3'b001) begin err++; $display("FAIL flush_block: got %b want 001", rdreq); end
      tick();
      vec++; if (out_valid !== 1'b1 || out_data !== 32'h00A3A2A1 || out_cnt !== 3'd3) begin
         err++; $display("FAIL flush_word: got v=%b %h cnt=%0d want v=1 00a3a2a1 cnt=3", out_valid, out_data, out_cnt); end
      vec++; if (rdreq !== 3'b100) begin err++; $display("FAIL flush_resume: got %b want 100", rdreq); end
      q.delete();
      settle();
      tick();
      flush = 1'b1;
      settle();
      tick();
      flush = 1'b0;
      settle();
      vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL flush_empty0: got %b want 0", out_valid); end
      tick();
      vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL flush_empty1: got %b want 0", out_valid); end
   endtask

   task automatic test_reset_mid();
      q.push_back(8'h61); q.push_back(8'h62);
      settle();
      tick();
      q.push_back(8'h77); q.push_back(8'h78);
      rst = 1'b1;
      settle();
      vec++; if (rdreq !== 3'b001) begin err++; $display("FAIL rstmid_rdreq: got %b want 001", rdreq); end
      tick();
      rst = 1'b0;
      settle();
      vec++; if (out_valid !== 1'b0 || q.size() != 2) begin
         err++; $display("FAIL rstmid_state: got v=%b words=%0d want v=0 words=2", out_valid, q.size()); end
      vec++; if (rdreq !== 3'b100) begin err++; $display("FAIL rstmid_rdreq2: got %b want 100", rdreq); end
      tick();
      q.push_back(8'h79); q.push_back(8'h7A);
      settle();
      tick();
      vec++; if (out_data[7:0] !== 8'h77) begin err++; $display("FAIL rstmid_lane0: got %h want 77", out_data[7:0]); end
      vec++; if (out_valid !== 1'b1 || out_data !== 32'h7A797877 || out_cnt !== 3'd4) begin
         err++; $display("FAIL rstmid_word: got v=%b %h cnt=%0d want v=1 7a797877 cnt=4", out_valid, out_data, out_cnt); end
   endtask

   initial begin
      vec = 0;
      err = 0;
      rst = 1'b1;
      flush = 1'b0;
      out_ready = 1'b1;
      one_max = 1'b0;
      test_reset();
      test_stream();
      test_single();
      test_odd();
      test_backpressure();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule
